// File: rtl/top_level_inst.sv
// Hamming SEC-DED encoder engine: reads 11-bit messages from dm1 and writes back 16-bit codewords.
// Optional STATUS_COUNT_EN adds a msg_count status output counting codewords written.

module top_level_inst_dmem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       clock,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [0:MEM_DEPTH-1];

  assign rdata = core[addr];

  // No reset on the array so a preload applied before or during reset survives.
  always_ff @(posedge clock) begin
    if (we) core[addr] <= wdata;
  end

endmodule

module top_level_inst #(
  parameter int NUM_MSG   = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
`ifdef STATUS_COUNT_EN
  output logic [3:0] msg_count,
`endif
  output logic       done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [7:0]  lo_q, lo_d;
  logic [2:0]  hi_q, hi_d;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;

  logic [11:1] d;
  logic        p8, p4, p2, p1, p0;
  logic [7:0]  cw_hi, cw_lo;
  logic        accept;

  top_level_inst_dmem #(.MEM_DEPTH(MEM_DEPTH)) dm1 (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign src_addr = 8'(SRC_BASE) + {3'b000, idx_q, 1'b0};
  assign dst_addr = 8'(DST_BASE) + {3'b000, idx_q, 1'b0};

  assign d  = {hi_q, lo_q};
  assign p8 = ^d[11:5];
  assign p4 = (^d[11:8]) ^ (^d[4:2]);
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

  assign cw_hi = {d[11:5], p8};
  assign cw_lo = {d[4:2], p4, d[1], p2, p1, p0};

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = src_addr;
    mem_wdata = cw_lo;
    case (state_q)
      RD_HI: mem_addr = src_addr + 8'd1;
      WR_LO: begin
        mem_we   = 1'b1;
        mem_addr = dst_addr;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = dst_addr + 8'd1;
        mem_wdata = cw_hi;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_LO;
          idx_d   = 4'd0;
          done_d  = 1'b0;
        end
      end
      RD_LO: begin
        lo_d    = mem_rdata;
        state_d = RD_HI;
      end
      RD_HI: begin
        hi_d    = mem_rdata[2:0];
        state_d = WR_LO;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        if (idx_q == 4'(NUM_MSG - 1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = RD_LO;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      lo_q    <= 8'd0;
      hi_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign done = done_q;

`ifdef STATUS_COUNT_EN
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                 cnt_d = 4'd0;
    else if (state_q == WR_HI)  cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end

  assign msg_count = cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_top_level_inst.sv
// Self-checking bench for top_level_inst: directed and random encode passes against a positional Hamming model.
// Expected memory image is kept by the bench; codewords come from the textbook position-based construction.

module tb_top_level_inst;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic done;
`ifdef STATUS_COUNT_EN
  logic [3:0] msg_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [10:0] msgs [15];
  logic [7:0]  img  [256];

  always #5 clock = ~clock;

  top_level_inst dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
`ifdef STATUS_COUNT_EN
    .msg_count (msg_count),
`endif
    .done      (done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, done=%b", done);
    $fatal(1, "watchdog");
  end

  // Codeword bit k holds Hamming position k (1..15); bit 0 is overall parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] m);
    logic [15:0] c;
    logic [3:0]  p;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = m[j];
        j++;
      end
    end
    p = '0;
    for (int k = 0; k < 4; k++)
      for (int pos = 1; pos < 16; pos++)
        if ((pos >> k) & 1) p[k] = p[k] ^ c[pos];
    for (int k = 0; k < 4; k++) c[1 << k] = p[k];
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) begin
      img[a] = 8'($urandom);
      dut.dm1.core[a] = img[a];
    end
  endtask

  task automatic load_msgs(input bit directed);
    logic [10:0] dir [4];
    logic [7:0]  hi;
    dir = '{11'h000, 11'h7FF, 11'h001, 11'h400};
    for (int i = 0; i < 15; i++) begin
      msgs[i] = (directed && i < 4) ? dir[i] : 11'($urandom);
      hi = {5'($urandom), msgs[i][10:8]};
      if (directed && i == 3) hi = 8'hFC;
      img[2*i]   = msgs[i][7:0];
      img[2*i+1] = hi;
      dut.dm1.core[2*i]   = img[2*i];
      dut.dm1.core[2*i+1] = img[2*i+1];
    end
  endtask

  task automatic apply_codewords(input int k);
    logic [15:0] cw;
    for (int i = 0; i < k; i++) begin
      cw = ref_cw(msgs[i]);
      img[30+2*i] = cw[7:0];
      img[31+2*i] = cw[15:8];
    end
  endtask

  task automatic check_mem(input string tag);
    logic [15:0] got, exp;
    int bad, first;
    for (int i = 0; i < 15; i++) begin
      got = {dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]};
      exp = {img[31+2*i], img[30+2*i]};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s cw[%0d]: got %h expected %h", tag, i, got, exp);
      end
    end
    bad = 0;
    first = -1;
    for (int a = 0; a < 256; a++) begin
      if (a < 30 || a > 59) begin
        if (dut.dm1.core[a] !== img[a]) begin
          bad++;
          if (first < 0) first = a;
        end
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s untouched: %0d bytes changed, first at %0d got %h expected %h",
               tag, bad, first, dut.dm1.core[first], img[first]);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_pass(input int pulse_at, output int n, output logic first_done);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    first_done = done;
    n = 0;
    while (n < 200 && done !== 1'b1) begin
      start = (n == pulse_at);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_latency(input string tag, input int n);
    tests_run++;
    if (n != 61 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s latency: done=%b after %0d edges, expected 1 after 61", tag, done, n);
    end
`ifdef STATUS_COUNT_EN
    tests_run++;
    if (msg_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL %s msg_count: got %0d expected 15", tag, msg_count);
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset done: got %b expected 0", done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle done: got %b expected 0", done);
    end
`ifdef STATUS_COUNT_EN
    tests_run++;
    if (msg_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset msg_count: got %0d expected 0", msg_count);
    end
`endif
    check_mem("preload");
  endtask

  task automatic test_directed();
    int n;
    logic fd;
    int          addr [8];
    logic [7:0]  val  [8];
    addr = '{31, 30, 33, 32, 35, 34, 37, 36};
    val  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h81, 8'h17};
    run_pass(-1, n, fd);
    check_latency("directed", n);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (dut.dm1.core[addr[i]] !== val[i]) begin
        tests_failed++;
        $display("FAIL directed core[%0d]: got %h expected %h", addr[i], dut.dm1.core[addr[i]], val[i]);
      end
    end
    apply_codewords(15);
    check_mem("directed");
  endtask

  task automatic test_random();
    int n;
    logic fd;
    fill_mem();
    load_msgs(1'b0);
    run_pass(30, n, fd);
    check_latency("random", n);
    apply_codewords(15);
    check_mem("random");
  endtask

  task automatic test_restart();
    int n;
    logic fd;
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold done: got %b expected 1", done);
    end
    run_pass(-1, n, fd);
    tests_run++;
    if (fd !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart clear: done=%b after accepting edge, expected 0", fd);
    end
    check_latency("restart", n);
    check_mem("restart");
  endtask

  task automatic test_reset_midrun();
    int n;
    fill_mem();
    load_msgs(1'b0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun reset done: got %b expected 0", done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL post-abort done: got %b expected 0", done);
    end
    apply_codewords(5);
    check_mem("abort");
    begin
      logic fd;
      run_pass(-1, n, fd);
    end
    check_latency("rerun", n);
    apply_codewords(15);
    check_mem("rerun");
  endtask

  initial begin
    reset_n = 1'b0;
    fill_mem();
    load_msgs(1'b1);
    repeat (3) @(posedge clock);
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
